// File: rtl/inst_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
// The loader side uses modport master; the source/memory side uses slave.
interface inst_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: assembles MSB-first bytes into 32-bit words and writes
// them to consecutive memory indices, holding the CPU until a load completes.
module inst_loader #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [10:0]   word_count,
    inst_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [11:0] DEPTH = 12'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [10:0] cnt_q;
    logic [10:0] idx_q;
    logic [1:0]  bcnt_q;
    logic [31:0] asm_q;

    logic count_ok, start_ok, last_word;

    assign count_ok  = (word_count != 11'd0) && ({1'b0, word_count} <= DEPTH);
    assign start_ok  = start && count_ok;
    assign last_word = (idx_q == cnt_q - 11'd1);

    assign bus.wr_addr = 32'(idx_q);
    assign bus.wr_data = asm_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.byte_ready = 1'b0;
        bus.wr_en      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = RECV;
            end
            RECV: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid && bcnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                bus.wr_en = 1'b1;
                busy      = 1'b1;
                state_d   = last_word ? DONE : RECV;
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) state_d = RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        cnt_q    <= word_count;
                        idx_q    <= '0;
                        bcnt_q   <= '0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                RECV: begin
                    if (bus.byte_valid) begin
                        asm_q  <= {asm_q[23:0], bus.byte_data};
                        bcnt_q <= bcnt_q + 2'd1;
                    end
                end
                WRITE: begin
                    // The index is held on the final word so it never reaches MEM_DEPTH.
                    if (last_word) cpu_hold <= 1'b0;
                    else           idx_q    <= idx_q + 11'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: start-acceptance table, directed load
// sequences, randomized loads against a word-list model, and a full-depth load.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] word_count = '0;
    logic        busy, done, err, cpu_hold;

    inst_loader_if bus_if ();

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    typedef struct {
        logic [10:0] wc;
        logic        exp_err;
        logic        exp_busy;
    } start_vec_t;

    inst_loader #(.MEM_DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus_if.wr_en === 1'b1) got_q.push_back({bus_if.wr_addr, bus_if.wr_data});

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic start_load(input logic [10:0] wc);
        start      = 1'b1;
        word_count = wc;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit ok = 1'b0;
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.byte_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) begin
            cyc();
        end else begin
            nvec++;
            nerr++;
            $display("FAIL byte_accept: got ready=0 for 20 cycles, expected ready=1");
        end
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'hFF;
        repeat (gap) cyc();
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int unsigned k = 0; k < 4; k++)
            send_byte(w[31 - 8*k -: 8], gap);
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            cyc();
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic check_writes(input string name);
        int unsigned n;
        int unsigned bad = 0;
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (bad == 0)
                    $display("FAIL %s_entry%0d: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             name, i, got_q[i][63:32], got_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
                bad++;
            end
        end
        check({name, "_bad_entries"}, bad, 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        start_vec_t tbl[6];
        logic [31:0] w;
        logic [10:0] wc;

        tbl[0] = '{wc: 11'd0,    exp_err: 1'b1, exp_busy: 1'b0};
        tbl[1] = '{wc: 11'd1025, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[2] = '{wc: 11'd2047, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[3] = '{wc: 11'd1,    exp_err: 1'b0, exp_busy: 1'b1};
        tbl[4] = '{wc: 11'd1024, exp_err: 1'b0, exp_busy: 1'b1};
        tbl[5] = '{wc: 11'd513,  exp_err: 1'b0, exp_busy: 1'b1};

        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'h00;

        // Reset state, sampled while rst is still low.
        cyc();
        cyc();
        check("rst_byte_ready", 32'(bus_if.byte_ready), 32'd0);
        check("rst_wr_en",      32'(bus_if.wr_en),      32'd0);
        check("rst_wr_addr",    bus_if.wr_addr,         32'd0);
        check("rst_wr_data",    bus_if.wr_data,         32'd0);
        check("rst_busy",       32'(busy),              32'd0);
        check("rst_done",       32'(done),              32'd0);
        check("rst_err",        32'(err),               32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),          32'd1);
        rst = 1'b1;
        cyc();

        // Start acceptance table, each vector from a fresh IDLE.
        for (int unsigned i = 0; i < 6; i++) begin
            do_reset();
            start_load(tbl[i].wc);
            check($sformatf("tbl%0d_err", i),      32'(err),      32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_busy", i),     32'(busy),     32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_cpu_hold", i), 32'(cpu_hold), 32'd1);
            check($sformatf("tbl%0d_wr_en", i),    32'(bus_if.wr_en), 32'd0);
        end
        do_reset();
        check_writes("tbl");

        // Two-word load with write-latency checks.
        start_load(11'd2);
        check("load_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h8C, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("load_lat_wr_en",   32'(bus_if.wr_en), 32'd1);
        check("load_lat_wr_addr", bus_if.wr_addr,    32'd0);
        check("load_lat_wr_data", bus_if.wr_data,    32'h8C080000);
        cyc();
        check("load_wr_en_pulse", 32'(bus_if.wr_en), 32'd0);
        send_word(32'h8C090008, 0);
        exp_q.push_back({32'd0, 32'h8C080000});
        exp_q.push_back({32'd1, 32'h8C090008});
        wait_done("load_done", 10);
        check("load_cpu_hold", 32'(cpu_hold), 32'd0);
        check("load_busy",     32'(busy),     32'd0);
        check_writes("load");

        // Bad starts from DONE keep DONE/cpu_hold, then a valid start clears err.
        start_load(11'd0);
        check("dbad_err",  32'(err),      32'd1);
        check("dbad_done", 32'(done),     32'd1);
        check("dbad_hold", 32'(cpu_hold), 32'd0);
        start_load(11'd1025);
        check("dbad2_err", 32'(err),      32'd1);
        check("dbad2_busy", 32'(busy),    32'd0);
        start_load(11'd1);
        check("dgood_err",  32'(err),      32'd0);
        check("dgood_hold", 32'(cpu_hold), 32'd1);
        // Backpressure: three idle cycles between bytes.
        send_word(32'h8C0A0014, 3);
        exp_q.push_back({32'd0, 32'h8C0A0014});
        wait_done("bp_done", 10);
        repeat (4) cyc();
        check_writes("bp");

        // Mid-load reset aborts the partial word.
        start_load(11'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b0;
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = 8'hCC;
        cyc();
        check("abort_busy",  32'(busy),              32'd0);
        check("abort_ready", 32'(bus_if.byte_ready), 32'd0);
        check("abort_hold",  32'(cpu_hold),          32'd1);
        check("abort_done",  32'(done),              32'd0);
        rst = 1'b1;
        cyc();
        cyc();
        check("abort_idle_ready", 32'(bus_if.byte_ready), 32'd0);
        bus_if.byte_valid = 1'b0;
        check_writes("abort");
        start_load(11'd1);
        send_word(32'h12345678, 0);
        exp_q.push_back({32'd0, 32'h12345678});
        wait_done("reload_done", 10);
        check_writes("reload");

        // Start pulses while busy are ignored.
        start_load(11'd3);
        send_byte(8'h01, 0);
        start_load(11'd5);
        send_byte(8'h02, 0);
        start_load(11'd0);
        check("sbusy_err", 32'(err), 32'd0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_word(32'hA0B0C0D0, 1);
        send_word(32'h0F1E2D3C, 0);
        exp_q.push_back({32'd0, 32'h01020304});
        exp_q.push_back({32'd1, 32'hA0B0C0D0});
        exp_q.push_back({32'd2, 32'h0F1E2D3C});
        wait_done("sbusy_done", 10);
        check("sbusy_err2", 32'(err), 32'd0);
        check_writes("sbusy");

        // Randomized loads against the word-list model.
        for (int unsigned it = 0; it < 25; it++) begin
            wc = 11'($urandom_range(1, 6));
            start_load(wc);
            for (int unsigned i = 0; i < 32'(wc); i++) begin
                w = $urandom;
                exp_q.push_back({32'(i), w});
                for (int unsigned k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        start      = 1'b1;
                        word_count = 11'($urandom_range(0, 2047));
                        cyc();
                        start = 1'b0;
                    end
                    send_byte(w[31 - 8*k -: 8], $urandom_range(0, 2));
                end
            end
            wait_done($sformatf("rnd%0d_done", it), 10);
            check($sformatf("rnd%0d_hold", it), 32'(cpu_hold), 32'd0);
            check($sformatf("rnd%0d_err", it),  32'(err),      32'd0);
            check_writes($sformatf("rnd%0d", it));
        end

        // Full depth: last write lands on index 1023.
        start_load(11'd1024);
        for (int unsigned i = 0; i < 1024; i++) begin
            w = $urandom;
            exp_q.push_back({32'(i), w});
            send_word(w, 0);
        end
        wait_done("full_done", 10);
        check("full_hold", 32'(cpu_hold), 32'd0);
        repeat (3) cyc();
        check_writes("full");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning the number of 32-bit instruction words in the target memory.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset; sampled only on clk rising edge.
REQ-004 SHALL have port start, input, 1 bit: request to begin a load; sampled in IDLE and DONE only.
REQ-005 SHALL have port word_count, input, 11 bits: number of words to load; latched on an accepted start.
REQ-006 SHALL have port byte_valid, input, 1 bit: the source presents a byte on byte_data.
REQ-007 SHALL have port byte_data, input, 8 bits: the instruction byte stream, most significant byte of each word first.
REQ-008 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en, output, 1 bit: write strobe to the instruction memory.
REQ-010 SHALL have port wr_addr, output, 32 bits: word address (memory index) for the write.
REQ-011 SHALL have port wr_data, output, 32 bits: assembled instruction word.
REQ-012 SHALL have port busy, output, 1 bit: high in RECV and WRITE.
REQ-013 SHALL have port done, output, 1 bit: high in DONE.
REQ-014 SHALL have port err, output, 1 bit: sticky flag for a rejected start.
REQ-015 SHALL have port cpu_hold, output, 1 bit: holds the pipeline while memory contents are invalid or being rewritten.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-017 SHALL accept a byte only when byte_valid=1 and byte_ready=1 in the same cycle.
REQ-018 SHALL drive byte_ready=1 only in RECV.
REQ-019 SHALL, in IDLE or DONE, treat start=1 with 1 <= word_count <= MEM_DEPTH as accepted: latch word_count, clear the address counter, clear the byte counter, clear err, set cpu_hold=1, and go to RECV.
REQ-020 SHALL, on start=1 with word_count=0 or word_count>MEM_DEPTH, set err=1 and keep state, address counter and cpu_hold unchanged.
REQ-021 SHALL ignore start while in RECV or WRITE; no restart and no err.
REQ-022 SHALL, in RECV, shift each accepted byte into the assembly register: byte 0 lands in [31:24] and byte 3 lands in [7:0].
REQ-023 SHALL move from RECV to WRITE on the cycle the 4th byte of a word is accepted; the 2-bit byte counter wraps to 0.
REQ-024 SHALL, in WRITE, drive for exactly one cycle: wr_en=1, wr_data=assembled word, wr_addr=current word index (zero-extended).
REQ-025 SHALL drive wr_en=0 in every state other than WRITE.
REQ-026 SHALL, on leaving WRITE, increment the word index; go to DONE if words written equals the latched count, otherwise return to RECV.
REQ-027 SHALL have a latency of 1 cycle from acceptance of the 4th byte to wr_en=1, and a minimum of 5 cycles per word.
REQ-028 SHALL hold partial-word state indefinitely while byte_valid=0 (gaps allowed, no timeout).
REQ-029 SHALL, in DONE, drive done=1 and cpu_hold=0, and remain in DONE until an accepted start.
REQ-030 SHALL write the highest index MEM_DEPTH-1 when word_count=MEM_DEPTH; the word index never exceeds MEM_DEPTH-1 and does not wrap.

Reset
REQ-031 SHALL, while rst=0 at a clk edge, enter IDLE with byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1, and all counters and the assembly register cleared.
REQ-032 SHALL treat reset during RECV or WRITE as an abort: no further write, the partial word is discarded, and cpu_hold stays 1 until a later load completes.

Verification
REQ-033 SHALL be checked by a load test: start with word_count=2, then bytes 8C 08 00 00 8C 09 00 08 -> writes addr0=0x8C080000 and addr1=0x8C090008, then done=1 and cpu_hold=0.
REQ-034 SHALL be checked by a backpressure test: 3 idle cycles between each byte of one word 0x8C0A0014 -> a single wr_en pulse with the correct data and no duplicate write.
REQ-035 SHALL be checked by a mid-load reset test: rst=0 after 2 bytes of word 1 -> no wr_en, IDLE, cpu_hold=1; a fresh load then writes from addr0.
REQ-036 SHALL be checked by a bad-count test: start with word_count=0 or 1025 in IDLE -> err=1, busy=0, no writes; a following valid start clears err.
REQ-037 SHALL be checked by a start-while-busy test: start pulsed during RECV of word 0 of 3 -> ignored; exactly 3 writes to addr0..addr2.
REQ-038 SHALL be checked by a full-depth test: word_count=1024 -> last write at addr 1023, then DONE, with no write at 1024.
